// File: rtl/sram_sync.sv
// Single-port synchronous SRAM with byte-enabled writes, a fixed two-edge response
// pipeline, and a zero-fill sequencer that sweeps the array one word per cycle.
module sram_sync #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 13,
  parameter int DEPTH      = 8192,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                clear_req,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both 1; req_ready is a register that is 1 exactly when the FSM is in IDLE.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_next;
  logic              ready_next;

  logic              accept;
  logic              addr_err;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              p_valid;
  logic              p_we;
  logic              p_err;
  logic [ADDR_W-1:0] p_addr;

  assign accept   = req_valid & req_ready;
  assign addr_err = ({1'b0, req_addr} >= DEPTH_EXT);
  assign busy     = (state == ST_CLEAR);

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        clr_cnt_next = '0;
      end
    endcase
    ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      req_ready <= ready_next;
    end
  end

  // Array has no reset; only the clear sweep and accepted in-range writes change it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (accept && req_we && !addr_err) begin
        for (int b = 0; b < NB; b++) begin
          if (req_be[b]) begin
            mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // First stage: capture the accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_we    <= 1'b0;
      p_err   <= 1'b0;
      p_addr  <= '0;
    end else begin
      p_valid <= accept;
      p_we    <= req_we;
      p_err   <= addr_err;
      p_addr  <= req_addr;
    end
  end

  // Second stage: read after the write edge so read-after-write sees new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= p_valid;
      rsp_err   <= p_valid & p_err;
      rsp_rdata <= (p_valid && !p_we && !p_err) ? mem[p_addr] : '0;
    end
  end

endmodule

// File: tb/tb_sram_sync.sv
// Directed bench for sram_sync: DATA_W=16, ADDR_W=4, DEPTH=12; a second
// instance with INIT_CLEAR=0 shares the inputs for the no-init-clear case.
module tb_sram_sync;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        clear_req;

  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic        n_req_ready, n_rsp_valid, n_rsp_err, n_busy;
  logic [15:0] n_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  sram_sync #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .clear_req(clear_req), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  sram_sync #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .INIT_CLEAR(0)) dut_n (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(n_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .clear_req(clear_req), .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata),
    .rsp_err(n_rsp_err), .busy(n_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request (waiting for ready on the selected instance) and returns
  // rsp_valid just after the accept edge plus the response after the next edge.
  task automatic do_req(input bit sel, input bit we, input logic [3:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input bit clr,
                        output bit timeout, output bit rv_early, output bit rv,
                        output logic [15:0] rd, output bit er);
    int n = 0;
    timeout = 1'b0; rv_early = 1'b0; rv = 1'b0; rd = '0; er = 1'b0;
    while (((sel ? n_req_ready : req_ready) !== 1'b1) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      timeout = 1'b1;
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    clear_req = clr;
    step();
    req_valid = 1'b0; clear_req = 1'b0;
    rv_early = sel ? n_rsp_valid : rsp_valid;
    step();
    rv = sel ? n_rsp_valid : rsp_valid;
    rd = sel ? n_rsp_rdata : rsp_rdata;
    er = sel ? n_rsp_err : rsp_err;
  endtask

  task automatic test_reset();
    bit to, rve, rv, er;
    logic [15:0] rd;
    int cnt;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b0001 || rsp_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready/valid/err/busy=%b rdata=%h required 0001/0000", {req_ready, rsp_valid, rsp_err, busy}, rsp_rdata);
    end
    checks++;
    if (n_busy !== 1'b0 || n_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_noinit: busy=%b ready=%b required 0 0", n_busy, n_req_ready);
    end
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    checks++;
    if (cnt != 12) begin
      failures++;
      $display("FAIL init_clear_len: busy cycles=%0d required 12", cnt);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_clear: got %b required 1", req_ready);
    end
    for (int a = 0; a < 12; a++) begin
      do_req(1'b0, 1'b0, 4'(a), 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
      checks++;
      if (to || rv !== 1'b1 || rd !== 16'h0000 || er !== 1'b0) begin
        failures++;
        $display("FAIL init_read[%0d]: to=%b valid=%b rdata=%h err=%b required 0 1 0000 0", a, to, rv, rd, er);
      end
    end
  endtask

  task automatic test_byte_enable();
    bit to, rve, rv, er;
    logic [15:0] rd;
    do_req(1'b0, 1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || rd !== 16'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL write_full_ack: to=%b valid=%b rdata=%h err=%b required 0 1 0000 0", to, rv, rd, er);
    end
    do_req(1'b0, 1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || er !== 1'b0) begin
      failures++;
      $display("FAIL write_low_ack: to=%b valid=%b err=%b required 0 1 0", to, rv, er);
    end
    do_req(1'b0, 1'b0, 4'd3, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rve !== 1'b0 || rv !== 1'b1 || rd !== 16'hAB34) begin
      failures++;
      $display("FAIL be_merge: to=%b early=%b valid=%b rdata=%h required 0 0 1 ab34", to, rve, rv, rd);
    end
    do_req(1'b0, 1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, to, rve, rv, rd, er);
    do_req(1'b0, 1'b0, 4'd3, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || rd !== 16'hAB34) begin
      failures++;
      $display("FAIL be_zero: to=%b valid=%b rdata=%h required 0 1 ab34", to, rv, rd);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 16'h00FF; req_be = 2'b11;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: got %b required 1", req_ready);
    end
    req_we = 1'b0; req_wdata = 16'h0;
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0) begin
      failures++;
      $display("FAIL b2b_write_rsp: valid=%b rdata=%h required 1 0000", rsp_valid, rsp_rdata);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h00FF || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_read_rsp: valid=%b rdata=%h err=%b required 1 00ff 0", rsp_valid, rsp_rdata, rsp_err);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_outputs: valid=%b rdata=%h err=%b required 0 0000 0", rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_out_of_range();
    bit to, rve, rv, er;
    logic [15:0] rd;
    do_req(1'b0, 1'b0, 4'd12, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || er !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL oor_read: to=%b valid=%b err=%b rdata=%h required 0 1 1 0000", to, rv, er, rd);
    end
    do_req(1'b0, 1'b1, 4'd15, 16'hFFFF, 2'b11, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || er !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL oor_write: to=%b valid=%b err=%b rdata=%h required 0 1 1 0000", to, rv, er, rd);
    end
    do_req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || er !== 1'b0 || rd !== 16'h0) begin
      failures++;
      $display("FAIL oor_no_alias: to=%b valid=%b err=%b rdata=%h required 0 1 0 0000", to, rv, er, rd);
    end
  endtask

  task automatic test_clear_collision();
    bit to, rve, rv, er;
    logic [15:0] rd;
    int cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 16'h5555; req_be = 2'b11;
    clear_req = 1'b1;
    step();
    req_valid = 1'b0; clear_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_enter: busy=%b ready=%b required 1 0", busy, req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL clr_write_ack: valid=%b err=%b required 1 0", rsp_valid, rsp_err);
    end
    cnt = 1;
    while (busy === 1'b1 && cnt < 100) begin
      clear_req = (cnt == 4);
      step();
      cnt++;
    end
    clear_req = 1'b0;
    checks++;
    if (cnt != 12) begin
      failures++;
      $display("FAIL clr_len: busy cycles=%0d required 12", cnt);
    end
    do_req(1'b0, 1'b0, 4'd7, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL clr_addr7: to=%b valid=%b rdata=%h required 0 1 0000", to, rv, rd);
    end
    do_req(1'b0, 1'b0, 4'd3, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL clr_addr3: to=%b valid=%b rdata=%h required 0 1 0000", to, rv, rd);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit to, rve, rv, er;
    logic [15:0] rd;
    int cnt;
    bit saw_rsp;
    do_req(1'b0, 1'b1, 4'd1, 16'h4242, 2'b11, 1'b0, to, rve, rv, rd, er);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    step();
    req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_drop_rsp: valid=%b busy=%b required 0 1", rsp_valid, busy);
    end
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    saw_rsp = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
      step();
      cnt++;
    end
    checks++;
    if (cnt != 12 || saw_rsp) begin
      failures++;
      $display("FAIL rst_restart_clear: busy cycles=%0d saw_rsp=%b required 12 0", cnt, saw_rsp);
    end
    do_req(1'b0, 1'b0, 4'd1, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL rst_cleared_addr1: to=%b valid=%b rdata=%h required 0 1 0000", to, rv, rd);
    end
  endtask

  task automatic test_no_init_clear();
    bit to, rve, rv, er;
    logic [15:0] rd;
    do_req(1'b1, 1'b1, 4'd2, 16'h9999, 2'b11, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1) begin
      failures++;
      $display("FAIL ni_write_ack: to=%b valid=%b required 0 1", to, rv);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (n_busy !== 1'b0 || n_req_ready !== 1'b0 || n_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL ni_reset: busy=%b ready=%b valid=%b required 0 0 0", n_busy, n_req_ready, n_rsp_valid);
    end
    step();
    checks++;
    if (n_req_ready !== 1'b1 || n_busy !== 1'b0) begin
      failures++;
      $display("FAIL ni_ready_after_rst: ready=%b busy=%b required 1 0", n_req_ready, n_busy);
    end
    do_req(1'b1, 1'b0, 4'd2, 16'h0, 2'b00, 1'b0, to, rve, rv, rd, er);
    checks++;
    if (to || rv !== 1'b1 || rd !== 16'h9999) begin
      failures++;
      $display("FAIL ni_mem_kept: to=%b valid=%b rdata=%h required 0 1 9999", to, rv, rd);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; clear_req = 1'b0;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_clear_collision();
    test_reset_mid_clear();
    test_no_init_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_sync.md
SRAM_SYNC -- requirements
Module: sram_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 13, address width.
REQ-003 SHALL have parameter DEPTH, default 8192, number of words; 1 <= DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter INIT_CLEAR, default 1; 1 = zero-fill memory after reset.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  block accepts a request this cycle.
REQ-009 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  in  ADDR_W  word address.
REQ-011 SHALL have port req_wdata  in  DATA_W  write data.
REQ-012 SHALL have port req_be  in  DATA_W/8  byte enables for writes.
REQ-013 SHALL have port clear_req  in  1  start a zero-fill of the whole memory.
REQ-014 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-015 SHALL have port rsp_rdata  out  DATA_W  read data.
REQ-016 SHALL have port rsp_err  out  1  address out of range; qualified by rsp_valid.
REQ-017 SHALL have port busy  out  1  zero-fill in progress.

Function
REQ-018 SHALL use a two-state FSM, CLEAR and IDLE; req_ready = 1 only in IDLE and is driven from a register, never combinationally from inputs.
REQ-019 A request SHALL be accepted on any edge where req_valid and req_ready are both 1; at most one is accepted per cycle.
REQ-020 For a request accepted at edge N, the block SHALL assert rsp_valid for exactly one cycle after edge N+1. Reads and writes both get a response.
REQ-021 Read response: rsp_rdata = mem[req_addr]; rsp_err = 0.
REQ-022 Write: each byte i with req_be[i] = 1 SHALL be updated at edge N. Bytes with req_be[i] = 0 SHALL be unchanged. Response has rsp_rdata = 0 and rsp_err = 0.
REQ-023 A write with req_be all-zero SHALL leave memory unchanged and still produce a response.
REQ-024 A read accepted at the edge after a write to the same address SHALL return the newly written data.
REQ-025 Back-to-back requests on consecutive cycles SHALL be accepted without stalls, giving consecutive rsp_valid pulses.
REQ-026 If req_addr >= DEPTH: no memory change, rsp_rdata = 0, rsp_err = 1.
REQ-027 Outside a response cycle, rsp_rdata and rsp_err SHALL be 0.
REQ-028 CLEAR state: an address counter starts at 0 and writes 0 to one word per cycle. After writing word DEPTH-1, the FSM SHALL go to IDLE, so CLEAR lasts exactly DEPTH cycles. busy = 1 throughout CLEAR.
REQ-029 clear_req sampled 1 in IDLE SHALL enter CLEAR at that edge.
REQ-030 If clear_req and an accepted request coincide, the request SHALL still complete and respond; CLEAR starts at the same edge.
REQ-031 clear_req SHALL be ignored while in CLEAR; it does not restart the counter.
REQ-032 Memory contents SHALL NOT be reset by rst; only CLEAR modifies them other than writes.

Reset
REQ-033 While rst = 1 at an edge:
- req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Clear counter = 0.
- State = CLEAR with busy = 1 if INIT_CLEAR = 1; otherwise IDLE with busy = 0.
REQ-034 rst SHALL override all other inputs, including in the same cycle as a request.
REQ-035 rst mid-CLEAR or mid-response: the pending response SHALL be dropped, and with INIT_CLEAR = 1 the clear SHALL restart from address 0.
REQ-036 With INIT_CLEAR = 0, req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (DATA_W=16, ADDR_W=4, DEPTH=12, INIT_CLEAR=1 unless stated)
REQ-037 Release rst -> busy = 1 for exactly 12 cycles, then req_ready = 1; reads of addresses 0..11 all return 0x0000.
REQ-038 Write addr 3 data 0xABCD be=11, then write addr 3 data 0x1234 be=01, then read addr 3 -> rsp_rdata = 0xAB34, one cycle after acceptance.
REQ-039 Back-to-back: write addr 5 = 0x00FF, then read addr 5 the next cycle -> 0x00FF; rsp_valid is high for 2 consecutive cycles.
REQ-040 Read addr 12 and write addr 15 with 0xFFFF -> rsp_err = 1 and rsp_rdata = 0 on both; a read of addr 0 afterwards still returns its previous value.
REQ-041 Write addr 7 = 0x5555 in the same cycle as clear_req -> write acks, busy = 1 for 12 cycles, then read addr 7 -> 0x0000.
REQ-042 Assert rst for 1 cycle in the 5th CLEAR cycle -> no rsp_valid, busy stays 1 for 12 more cycles. With INIT_CLEAR = 0: write addr 2 = 0x9999, pulse rst, read addr 2 -> 0x9999.
